// File: rtl/instr_fetch_issue.sv
// rtl/instr_fetch_issue.sv - PC holder, instruction fetch over req/ready, field issue over valid/ready
module instr_fetch_issue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm16,
    output logic [25:0] jtarget,
    output logic [31:0] issue_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err,
    output logic [31:0] issued_count
);

    typedef enum logic [1:0] {FETCH, ISSUE, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] drain_addr;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            ir           <= 32'h0;
            issue_pc     <= 32'h0;
            drain_addr   <= RESET_PC;
            misalign_err <= 1'b0;
            issued_count <= 32'h0;
        end else begin
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        pc <= redirect_aligned;
                        // The outstanding request must complete at its original address.
                        if (!imem_ready) begin
                            drain_addr <= pc;
                            state      <= DRAIN;
                        end
                    end else if (imem_ready) begin
                        ir       <= imem_rdata;
                        issue_pc <= pc;
                        state    <= ISSUE;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        pc <= redirect_aligned;
                    end
                    if (imem_ready) begin
                        state <= FETCH;
                    end
                end
                ISSUE: begin
                    if (issue_ready) begin
                        issued_count <= issued_count + 32'd1;
                    end
                    if (redirect_valid) begin
                        pc    <= redirect_aligned;
                        state <= FETCH;
                    end else if (issue_ready) begin
                        pc    <= pc + PC_STEP;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Gating with rst_n drops the request the instant reset asserts.
    assign imem_req    = rst_n && (state != ISSUE);
    assign imem_addr   = (state == DRAIN) ? drain_addr : pc;
    assign issue_valid = (state == ISSUE);

    assign opcode  = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign shamt   = ir[10:6];
    assign funct   = ir[5:0];
    assign imm16   = ir[15:0];
    assign jtarget = ir[25:0];

endmodule

// File: tb/tb_instr_fetch_issue.sv
// tb/tb_instr_fetch_issue.sv - self-checking bench for instr_fetch_issue
module tb_instr_fetch_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        issue_valid;
    logic        issue_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] issue_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;
    logic [31:0] issued_count;
    logic [31:0] mem_word;

    int tests = 0;
    int fails = 0;

    instr_fetch_issue #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm16(imm16), .jtarget(jtarget), .issue_pc(issue_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_err(misalign_err), .issued_count(issued_count)
    );

    always #5 clk = ~clk;
    assign imem_rdata = mem_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: the PC the next useful fetch must target, the instruction
    // awaiting issue, whether an abandoned fetch is still in flight, and counters.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    ent_t        pend[$];
    logic [31:0] fetch_log[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_mis;
    logic        stale;
    logic [31:0] stale_addr;
    logic        prev_wait;
    logic [31:0] prev_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_req", imem_req, 1'b0);
            check("rst_valid", issue_valid, 1'b0);
            check("rst_count", issued_count, 32'h0);
            check("rst_mis", misalign_err, 1'b0);
            check("rst_fields", {opcode, rs, rt, rd, shamt, funct}, 32'h0);
            check("rst_issue_pc", issue_pc, 32'h0);
            pend.delete();
            m_pc = 32'h0; m_cnt = 32'h0; m_mis = 1'b0;
            stale = 1'b0; prev_wait = 1'b0;
        end else begin
            check("count", issued_count, m_cnt);
            check("misalign", misalign_err, m_mis);
            check("req_vs_valid", imem_req, !issue_valid);
            check("valid", issue_valid, pend.size() > 0);
            if (issue_valid && pend.size() > 0) begin
                check("fields", {opcode, rs, rt, rd, shamt, funct}, pend[0].w);
                check("imm16", imm16, {16'h0, pend[0].w[15:0]});
                check("jtarget", jtarget, {6'h0, pend[0].w[25:0]});
                check("issue_pc", issue_pc, pend[0].pc);
            end
            if (prev_wait) begin
                check("req_held", imem_req, 1'b1);
                check("addr_stable", imem_addr, prev_addr);
            end
            prev_wait = imem_req && !imem_ready;
            prev_addr = imem_addr;

            if (redirect_valid && redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
            if (imem_req && imem_ready) begin
                fetch_log.push_back(imem_addr);
                if (stale) begin
                    check("drain_addr", imem_addr, stale_addr);
                    stale = 1'b0;
                end else begin
                    check("fetch_addr", imem_addr, m_pc);
                    if (!redirect_valid) pend.push_back('{m_pc, imem_rdata});
                end
            end else if (imem_req && redirect_valid && !stale) begin
                stale = 1'b1;
                stale_addr = m_pc;
            end
            if (issue_valid && pend.size() > 0 && (issue_ready || redirect_valid)) begin
                if (issue_ready) begin
                    m_cnt = m_cnt + 32'd1;
                    if (!redirect_valid) m_pc = m_pc + 32'd4;
                end
                void'(pend.pop_front());
            end
            if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; issue_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; mem_word = 32'h0022_1820;
        step(3);
        check("lit_rst_req", imem_req, 1'b0);
        check("lit_rst_addr", imem_addr, 32'h0);

        // Zero-wait stream of add instructions.
        imem_ready = 1'b1; issue_ready = 1'b1; rst_n = 1'b1;
        #1;
        check("lit_first_req", imem_req, 1'b1);
        check("lit_first_addr", imem_addr, 32'h0);
        fetch_log.delete();
        step(6);
        check("lit_count3", issued_count, 32'd3);
        check("lit_nfetch", fetch_log.size(), 3);
        if (fetch_log.size() == 3) begin
            check("lit_addr0", fetch_log[0], 32'h0);
            check("lit_addr1", fetch_log[1], 32'h4);
            check("lit_addr2", fetch_log[2], 32'h8);
        end
        check("lit_add", {opcode, rs, rt, rd, funct}, {6'h0, 5'd1, 5'd2, 5'd3, 6'h20});

        // Stalled issue of a lw word.
        mem_word = 32'h8C43_0004; issue_ready = 1'b0;
        step(1);
        check("lit_lw_valid", issue_valid, 1'b1);
        check("lit_lw_op", {opcode, imm16}, {6'h23, 16'h0004});
        check("lit_lw_pc", issue_pc, 32'hC);
        step(5);
        check("lit_stall_req", imem_req, 1'b0);
        check("lit_stall_pc", issue_pc, 32'hC);
        check("lit_stall_cnt", issued_count, 32'd3);
        issue_ready = 1'b1;
        step(1);
        check("lit_release_cnt", issued_count, 32'd4);

        // Redirect during a slow fetch: DRAIN keeps the old address.
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        step(1);
        redirect_valid = 1'b0;
        check("lit_drain_addr", imem_addr, 32'h10);
        step(2);
        check("lit_drain_hold", imem_addr, 32'h10);
        imem_ready = 1'b1; issue_ready = 1'b0;
        step(1);
        check("lit_drain_noissue", issue_valid, 1'b0);
        check("lit_new_addr", imem_addr, 32'h100);
        step(1);
        check("lit_issue_100", issue_pc, 32'h100);

        // Redirect in ISSUE coincident with handshake.
        redirect_valid = 1'b1; redirect_pc = 32'h200; issue_ready = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        check("lit_redir_cnt", issued_count, 32'd5);
        check("lit_redir_addr", imem_addr, 32'h200);

        // Misaligned redirect coincident with a fetch completion.
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        step(1);
        redirect_valid = 1'b0;
        check("lit_mis_set", misalign_err, 1'b1);
        check("lit_mis_addr", imem_addr, 32'h200);
        step(4);
        check("lit_mis_sticky", misalign_err, 1'b1);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; issue_ready = 1'b0;
        step(1);
        redirect_valid = 1'b0;
        check("lit_top_addr", imem_addr, 32'hFFFF_FFFC);
        step(1);
        issue_ready = 1'b1;
        check("lit_top_pc", issue_pc, 32'hFFFF_FFFC);
        step(1);
        check("lit_wrap_addr", imem_addr, 32'h0);

        // Reset while draining.
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
        step(1);
        redirect_valid = 1'b0;
        check("lit_pre_rst_req", imem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("lit_async_req", imem_req, 1'b0);
        check("lit_async_cnt", issued_count, 32'h0);
        check("lit_async_mis", misalign_err, 1'b0);
        check("lit_async_addr", imem_addr, 32'h0);
        step(2);
        rst_n = 1'b1; imem_ready = 1'b1; issue_ready = 1'b1;
        step(6);
        check("lit_post_cnt", issued_count, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
